// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg (package)
// Purpose  : Constants, types and helpers shared by the param_counter files.
//            Holds the mode constants (wrap/saturate), the direction
//            constants (down/up), the per-cycle action encoding and a
//            helper that sizes the prescaler counter.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

   // End-of-range behaviour selected by the mode input
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Count direction selected by the up_dn input
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   // Largest legal tick divisor
   localparam int unsigned PRESCALE_LIMIT = 65535;

   // What the counter does on a given edge, in priority order
   typedef enum logic [1:0] {
      ACT_HOLD  = 2'd0,
      ACT_STEP  = 2'd1,
      ACT_LOAD  = 2'd2,
      ACT_CLEAR = 2'd3
   } action_e;

   // Bits needed to hold 0..n-1, never less than one bit
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/param_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : param_counter_if (interface)
// Purpose  : Control and status bundle of the param_counter block.
// Ports    : master modport - drives en, up_dn, mode, clear, load, load_val
//                             and observes count, tc, sat
//            slave modport  - the counter side (inverse directions)
// Revision : 1.0  initial release
// ============================================================================
interface param_counter_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             up_dn;
   logic             mode;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             sat;

   modport master (
      output en, up_dn, mode, clear, load, load_val,
      input  count, tc, sat
   );

   modport slave (
      input  en, up_dn, mode, clear, load, load_val,
      output count, tc, sat
   );
endinterface : param_counter_if
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Divides enabled clock edges by PRESCALE. tick is high on every
//            PRESCALE-th edge that has en=1; the phase only advances while
//            en=1 and is cleared by restart.
// Ports    : clk     in  clock, rising edge
//            rst     in  asynchronous reset, active low
//            en      in  advance the phase on this edge
//            restart in  synchronous phase restart (wins over en)
//            tick    out current edge completes a period (combinational)
// Revision : 1.0  initial release
// ============================================================================
module tick_prescaler
   import counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic en,
   input  wire logic restart,
   output logic      tick
);

   localparam int unsigned   CW     = cnt_bits(PRESCALE);
   localparam logic [CW-1:0] C_LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] r_phase;
   logic          w_last;

   assign w_last = (r_phase == C_LAST);
   assign tick   = en && w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase <= '0;
      end else if (restart) begin
         r_phase <= '0;
      end else if (en) begin
         r_phase <= w_last ? '0 : r_phase + CW'(1);
      end
   end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_counter
// Purpose  : WIDTH-bit up/down counter with configurable upper limit MAX,
//            wrap or saturate end behaviour, synchronous clear/load, a
//            registered terminal-count pulse and a saturation flag.
//            Priority per edge: clear > load > step > hold.
//            Build option PARAM_COUNTER_PRESCALE_EN: when defined, steps are
//            gated by a tick_prescaler dividing enabled edges by PRESCALE;
//            when undefined, every enabled edge steps and PRESCALE is unused.
// Ports    : clk  in  clock, rising edge
//            rst  in  asynchronous reset, active low
//            bus  slave modport of param_counter_if:
//                 en, up_dn, mode, clear, load, load_val in
//                 count, tc, sat                         out (registered)
// Revision : 1.0  initial release
// ============================================================================
module param_counter
   import counter_pkg::*;
#(
   parameter int               WIDTH    = 3,
   parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
   parameter int unsigned      PRESCALE = 1
) (
   input  wire logic       clk,
   input  wire logic       rst,
   param_counter_if.slave  bus
);

   // Elaboration-time range checks on the configuration
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("param_counter: WIDTH must be in 1..32");
   end
   if (MAX == '0) begin : g_bad_max
      $error("param_counter: MAX must be at least 1");
   end
   if (PRESCALE < 1 || PRESCALE > PRESCALE_LIMIT) begin : g_bad_prescale
      $error("param_counter: PRESCALE must be in 1..65535");
   end

   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_sat;

   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_sat_nxt;
   logic             w_tick;
   logic             w_at_limit;
   action_e          w_act;

   // ------------------------------------------------------------------------
   // Tick source
   // ------------------------------------------------------------------------
`ifdef PARAM_COUNTER_PRESCALE_EN
   logic w_restart;

   // Clear or load starts a fresh prescale period
   assign w_restart = bus.clear | bus.load;

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .restart (w_restart),
      .tick    (w_tick)
   );
`else
   assign w_tick = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Action decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_act = ACT_HOLD;
      if (bus.clear) begin
         w_act = ACT_CLEAR;
      end else if (bus.load) begin
         w_act = ACT_LOAD;
      end else if (bus.en && w_tick) begin
         w_act = ACT_STEP;
      end
   end

   // Terminal value depends on the direction of the step being taken
   assign w_at_limit = (bus.up_dn == DIR_UP) ? (r_count == MAX)
                                             : (r_count == '0);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_count_nxt = r_count;
      w_tc_nxt    = 1'b0;
      w_sat_nxt   = r_sat;
      case (w_act)
         ACT_CLEAR: begin
            w_count_nxt = '0;
            w_sat_nxt   = 1'b0;
         end
         ACT_LOAD: begin
            // Out-of-range load values are clamped so count never exceeds MAX
            w_count_nxt = (bus.load_val > MAX) ? MAX : bus.load_val;
            w_sat_nxt   = 1'b0;
         end
         ACT_STEP: begin
            w_tc_nxt = w_at_limit;
            if (w_at_limit) begin
               if (bus.mode == MODE_SAT) begin
                  w_sat_nxt = 1'b1;
               end else begin
                  w_count_nxt = (bus.up_dn == DIR_UP) ? '0 : MAX;
                  w_sat_nxt   = 1'b0;
               end
            end else begin
               // Not at a limit, so +1 cannot pass MAX and -1 cannot underflow
               w_count_nxt = (bus.up_dn == DIR_UP) ? r_count + WIDTH'(1)
                                                   : r_count - WIDTH'(1);
               w_sat_nxt   = 1'b0;
            end
         end
         default: begin
            w_count_nxt = r_count;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_sat   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_tc    <= w_tc_nxt;
         r_sat   <= w_sat_nxt;
      end
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;
   assign bus.sat   = r_sat;

endmodule : param_counter
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_counter
// Purpose  : Directed self-checking bench for param_counter. Three instances:
//            u_c3 (WIDTH=3, default MAX), u_c4 (WIDTH=4, MAX=9) and
//            u_cp (WIDTH=3, PRESCALE=4) sharing one clock and reset.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_param_counter;

   logic clk;
   logic rst;

   int n_tests = 0;
   int n_fail  = 0;

   param_counter_if #(.WIDTH(3)) if3 ();
   param_counter_if #(.WIDTH(4)) if4 ();
   param_counter_if #(.WIDTH(3)) ifp ();

   param_counter #(.WIDTH(3)) u_c3 (
      .clk (clk),
      .rst (rst),
      .bus (if3.slave)
   );

   param_counter #(.WIDTH(4), .MAX(4'd9)) u_c4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   param_counter #(.WIDTH(3), .PRESCALE(4)) u_cp (
      .clk (clk),
      .rst (rst),
      .bus (ifp.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick_clk();
      @(posedge clk);
      #1;
   endtask

   logic [2:0] exp_pre [14];

   initial begin
      rst = 1'b0;
      if3.en = 0; if3.up_dn = 1; if3.mode = 0; if3.clear = 0; if3.load = 0; if3.load_val = '0;
      if4.en = 0; if4.up_dn = 1; if4.mode = 0; if4.clear = 0; if4.load = 0; if4.load_val = '0;
      ifp.en = 0; ifp.up_dn = 1; ifp.mode = 0; ifp.clear = 0; ifp.load = 0; ifp.load_val = '0;

`ifdef PARAM_COUNTER_PRESCALE_EN
      exp_pre = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                  3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
`else
      exp_pre = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                  3'd0, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4};
`endif

      // Reset state
      #12;
      check_eq("rst_c3_count", 32'(if3.count), 0);
      check_eq("rst_c3_tc",    32'(if3.tc),    0);
      check_eq("rst_c3_sat",   32'(if3.sat),   0);
      check_eq("rst_c4_count", 32'(if4.count), 0);
      check_eq("rst_cp_count", 32'(ifp.count), 0);

      // Wrap up from reset: first step on the first edge after release
      @(posedge clk); #1;
      rst = 1'b1;
      if3.en = 1; if3.up_dn = 1; if3.mode = 0;
      for (int i = 1; i <= 8; i++) begin
         tick_clk();
         check_eq($sformatf("up_wrap_count_%0d", i), 32'(if3.count), 32'(i % 8));
         check_eq($sformatf("up_wrap_tc_%0d", i),    32'(if3.tc),    (i == 8) ? 1 : 0);
      end

      // Wrap down from 0
      if3.up_dn = 0;
      tick_clk();
      check_eq("dn_wrap_count", 32'(if3.count), 7);
      check_eq("dn_wrap_tc",    32'(if3.tc),    1);
      if3.en = 0;
      tick_clk();
      check_eq("hold_count", 32'(if3.count), 7);
      check_eq("hold_tc",    32'(if3.tc),    0);

      // Saturate up from 6
      if3.load = 1; if3.load_val = 3'd6;
      tick_clk();
      check_eq("load6_count", 32'(if3.count), 6);
      if3.load = 0; if3.mode = 1; if3.up_dn = 1; if3.en = 1;
      tick_clk();
      check_eq("sat_up1_count", 32'(if3.count), 7);
      check_eq("sat_up1_tc",    32'(if3.tc),    0);
      check_eq("sat_up1_sat",   32'(if3.sat),   0);
      tick_clk();
      check_eq("sat_up2_count", 32'(if3.count), 7);
      check_eq("sat_up2_tc",    32'(if3.tc),    1);
      check_eq("sat_up2_sat",   32'(if3.sat),   1);
      if3.en = 0;
      tick_clk();
      check_eq("sat_hold_count", 32'(if3.count), 7);
      check_eq("sat_hold_tc",    32'(if3.tc),    0);
      check_eq("sat_hold_sat",   32'(if3.sat),   1);
      if3.en = 1; if3.up_dn = 0;
      tick_clk();
      check_eq("sat_dn_count", 32'(if3.count), 6);
      check_eq("sat_dn_sat",   32'(if3.sat),   0);
      check_eq("sat_dn_tc",    32'(if3.tc),    0);

      // Clear, then saturate at 0 going down
      if3.clear = 1;
      tick_clk();
      check_eq("clear_count", 32'(if3.count), 0);
      check_eq("clear_sat",   32'(if3.sat),   0);
      if3.clear = 0;
      tick_clk();
      check_eq("sat_zero_count", 32'(if3.count), 0);
      check_eq("sat_zero_sat",   32'(if3.sat),   1);
      check_eq("sat_zero_tc",    32'(if3.tc),    1);
      // Load beats an enabled step and clears sat
      if3.load = 1; if3.load_val = 3'd3;
      tick_clk();
      check_eq("load_pri_count", 32'(if3.count), 3);
      check_eq("load_pri_sat",   32'(if3.sat),   0);
      if3.load = 0; if3.en = 0;

      // WIDTH=4, MAX=9: clamped load, clear beats load, wrap at MAX
      if4.load = 1; if4.load_val = 4'd12;
      tick_clk();
      check_eq("c4_clamp_count", 32'(if4.count), 9);
      if4.clear = 1; if4.load_val = 4'd3;
      tick_clk();
      check_eq("c4_clr_load_count", 32'(if4.count), 0);
      if4.clear = 0; if4.load_val = 4'd9;
      tick_clk();
      check_eq("c4_load9_count", 32'(if4.count), 9);
      if4.load = 0; if4.en = 1; if4.up_dn = 1; if4.mode = 0;
      tick_clk();
      check_eq("c4_wrap_up_count", 32'(if4.count), 0);
      check_eq("c4_wrap_up_tc",    32'(if4.tc),    1);
      if4.up_dn = 0;
      tick_clk();
      check_eq("c4_wrap_dn_count", 32'(if4.count), 9);
      check_eq("c4_wrap_dn_tc",    32'(if4.tc),    1);
      if4.en = 0;

      // Prescaled instance; en low on edges 11 and 12
      ifp.clear = 1;
      tick_clk();
      check_eq("cp_clear_count", 32'(ifp.count), 0);
      ifp.clear = 0; ifp.up_dn = 1; ifp.mode = 0;
      for (int e = 1; e <= 14; e++) begin
         ifp.en = (e != 11 && e != 12);
         tick_clk();
         check_eq($sformatf("pre_count_e%0d", e), 32'(ifp.count), 32'(exp_pre[e-1]));
      end
      ifp.en = 0;

      // Asynchronous reset mid-count
      if3.load = 1; if3.load_val = 3'd4; if3.mode = 0; if3.up_dn = 1;
      tick_clk();
      if3.load = 0; if3.en = 1;
      tick_clk();
      check_eq("pre_rst_count", 32'(if3.count), 5);
      #2;
      rst = 1'b0;
      #1;
      check_eq("async_rst_count", 32'(if3.count), 0);
      check_eq("async_rst_tc",    32'(if3.tc),    0);
      check_eq("async_rst_sat",   32'(if3.sat),   0);
      check_eq("async_rst_c4",    32'(if4.count), 0);
      check_eq("async_rst_cp",    32'(ifp.count), 0);
      #1;
      rst = 1'b1;
      tick_clk();
      check_eq("post_rst_count", 32'(if3.count), 1);
      check_eq("post_rst_tc",    32'(if3.tc),    0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_param_counter
`default_nettype wire

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL take parameter WIDTH, default 3, as the counter width in bits (legal range 1..32).
REQ-002 The block SHALL take parameter MAX, default 2**WIDTH-1, as the upper terminal value (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL take parameter PRESCALE, default 1, as the count-tick divisor (legal range 1..65535).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; one clock, asynchronous assert, active-low.
REQ-006 en  input  1  count enable.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-008 mode  input  1  end behaviour: 0 = wrap, 1 = saturate.
REQ-009 clear  input  1  synchronous clear to 0.
REQ-010 load  input  1  synchronous load of load_val.
REQ-011 load_val  input  WIDTH  value to load.
REQ-012 count  output  WIDTH  registered count value.
REQ-013 tc  output  1  registered terminal-count pulse.
REQ-014 sat  output  1  registered flag: counter held at a limit in saturate mode.

Function
REQ-015 Per-cycle priority SHALL be: clear > load > step > hold.
REQ-016 clear SHALL set count=0, tc=0, sat=0 on the next edge and restart the prescaler.
REQ-017 load SHALL set count=min(load_val, MAX), tc=0, sat=0 and restart the prescaler.
REQ-018 A step SHALL occur on an edge only when en=1 and tick=1, with tick defined under Configuration.
REQ-019 Up step: count<MAX -> count+1; count==MAX -> 0 in wrap mode, or hold MAX in saturate mode.
REQ-020 Down step: count>0 -> count-1; count==0 -> MAX in wrap mode, or hold 0 in saturate mode.
REQ-021 tc SHALL be 1 for exactly the one cycle following any step taken while count was at its terminal value (MAX going up, 0 going down), and 0 otherwise.
REQ-022 sat SHALL be 1 after a saturate-mode step that holds at a limit, and SHALL stay 1 until the next non-holding step, clear, load or reset.
REQ-023 Changing up_dn or mode between steps SHALL take effect on the next step, with no extra latency.
REQ-024 With en=0 and no clear or load, count and sat SHALL hold and tc SHALL be 0.
REQ-025 A count outside 0..MAX SHALL be unreachable; all arithmetic is WIDTH bits with explicit compare to MAX, never relying on natural overflow.

Reset
REQ-026 While rst=0, count=0, tc=0, sat=0 and the prescaler state=0, asynchronously.
REQ-027 Reset release SHALL be synchronous to clk; the first step is possible on the first edge after release.
REQ-028 Reset asserted mid-count or mid-prescale SHALL discard all state, with no pending tc.

Configuration
REQ-029 Macro PARAM_COUNTER_PRESCALE_EN SHALL select the tick source.
REQ-030 With PARAM_COUNTER_PRESCALE_EN defined: tick=1 on every PRESCALE-th edge on which en=1; the prescaler counts only while en=1, holds when en=0, and restarts on clear or load. PRESCALE=1 gives tick=1 on every edge.
REQ-031 Without PARAM_COUNTER_PRESCALE_EN: tick is tied to 1, the PRESCALE parameter is ignored, and no prescaler logic is present.

Structure
REQ-032 Shared package counter_pkg SHALL hold the mode constants (MODE_WRAP=0, MODE_SAT=1) and the direction constants (DIR_DOWN=0, DIR_UP=1).
REQ-033 The prescaler SHALL be a sub-module, tick_prescaler (ports clk, rst, en, restart, tick), instantiated only under PARAM_COUNTER_PRESCALE_EN.

Verification
REQ-034 WIDTH=3, wrap, up, en=1 from reset -> count 0,1,...,7,0; tc=1 for one cycle after 7->0.
REQ-035 WIDTH=3, wrap, down from 0 -> count 7 next cycle; tc=1 for one cycle.
REQ-036 WIDTH=3, saturate, up from 6 -> 7, then holds 7; sat=1 and tc=1 after the first hold step; then up_dn=0 -> count 6 and sat=0.
REQ-037 WIDTH=4, MAX=9: load_val=12 -> count=9; clear and load in the same cycle -> count=0.
REQ-038 Macro defined, PRESCALE=4, en=1 -> count increments every 4th edge; en low for 2 cycles mid-period stretches that period by 2 cycles.
REQ-039 rst asserted at count=5 between edges -> count=0 and tc=0 immediately; after release, count=1 on the first edge.
